// File: rtl/ssd_scan_driver.sv
// Sun-count display: sequential double-dabble binary-to-BCD plus 4-digit 7-segment scan.
// Define LEADING_ZERO_BLANK_EN to blank digits above the most significant nonzero digit.
module ssd_scan_driver #(
    parameter int          REFRESH_W = 20,
    parameter logic [15:0] SAT_VALUE = 16'd9999
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] displayNumber,
    output logic [3:0]  anode,
    output logic [6:0]  ssdOut,
    output logic        busy,
    output logic [1:0]  state_dbg_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // Handshake: none; displayNumber is sampled only in IDLE, busy is high from
    // the sampling edge until the edge that publishes the new BCD value.

    state_t               state_q, state_d;
    logic [REFRESH_W-1:0] refresh_q, refresh_d;
    logic [15:0]          last_q, last_d;
    logic [31:0]          shift_q, shift_d;
    logic [3:0]           iter_q, iter_d;
    logic [15:0]          bcd_q, bcd_d;
    logic [3:0]           anode_q, anode_d;
    logic [6:0]           seg_q, seg_d;

    logic [1:0]           sel_w;
    logic [3:0]           digit_w;
    logic                 blank_w;
    logic [15:0]          sat_w;

    function automatic logic [31:0] dabble_step(input logic [31:0] v);
        logic [31:0] a;
        a = v;
        for (int i = 0; i < 4; i++) begin
            if (a[16 + 4*i +: 4] >= 4'd5) begin
                a[16 + 4*i +: 4] = a[16 + 4*i +: 4] + 4'd3;
            end
        end
        return {a[30:0], 1'b0};
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b0000001;
            4'd1:    s = 7'b1001111;
            4'd2:    s = 7'b0010010;
            4'd3:    s = 7'b0000110;
            4'd4:    s = 7'b1001100;
            4'd5:    s = 7'b0100100;
            4'd6:    s = 7'b0100000;
            4'd7:    s = 7'b0001111;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0000100;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    assign sat_w   = (displayNumber > SAT_VALUE) ? SAT_VALUE : displayNumber;
    assign sel_w   = refresh_q[REFRESH_W-1 -: 2];
    assign digit_w = bcd_q[{sel_w, 2'b00} +: 4];

    always_comb begin
        blank_w = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        // A digit is leading if it and every digit above it are zero; units never blanks.
        case (sel_w)
            2'd3:    blank_w = (bcd_q[15:12] == 4'd0);
            2'd2:    blank_w = (bcd_q[15:8]  == 8'd0);
            2'd1:    blank_w = (bcd_q[15:4]  == 12'd0);
            default: blank_w = 1'b0;
        endcase
`endif
    end

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        shift_d   = shift_q;
        iter_d    = iter_q;
        bcd_d     = bcd_q;
        refresh_d = refresh_q + {{(REFRESH_W-1){1'b0}}, 1'b1};
        anode_d   = ~(4'b0001 << sel_w);
        seg_d     = blank_w ? 7'b1111111 : seg_decode(digit_w);

        case (state_q)
            S_IDLE: begin
                if (displayNumber != last_q) begin
                    last_d  = displayNumber;
                    shift_d = {16'h0000, sat_w};
                    iter_d  = 4'd0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                shift_d = dabble_step(shift_q);
                iter_d  = iter_q + 4'd1;
                if (iter_q == 4'd15) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                // The old value stays on the display until the full result is ready.
                bcd_d   = shift_q[31:16];
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            refresh_q <= '0;
            last_q    <= 16'h0000;
            shift_q   <= 32'h0000_0000;
            iter_q    <= 4'd0;
            bcd_q     <= 16'h0000;
            anode_q   <= 4'b1110;
            seg_q     <= 7'b0000001;
        end else begin
            state_q   <= state_d;
            refresh_q <= refresh_d;
            last_q    <= last_d;
            shift_q   <= shift_d;
            iter_q    <= iter_d;
            bcd_q     <= bcd_d;
            anode_q   <= anode_d;
            seg_q     <= seg_d;
        end
    end

    assign anode       = anode_q;
    assign ssdOut      = seg_q;
    assign busy        = (state_q != S_IDLE);
    assign state_dbg_o = state_q;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Bench for ssd_scan_driver: decimal reference model checked every cycle, a vector
// table of displayed digits, and hand sequences for deferred input and mid-conversion reset.
module tb_ssd_scan_driver;

  localparam int RW = 4;

  localparam logic [6:0] S0 = 7'b0000001;
  localparam logic [6:0] S1 = 7'b1001111;
  localparam logic [6:0] S2 = 7'b0010010;
  localparam logic [6:0] S3 = 7'b0000110;
  localparam logic [6:0] S4 = 7'b1001100;
  localparam logic [6:0] S5 = 7'b0100100;
  localparam logic [6:0] S6 = 7'b0100000;
  localparam logic [6:0] S7 = 7'b0001111;
  localparam logic [6:0] S8 = 7'b0000000;
  localparam logic [6:0] S9 = 7'b0000100;
  localparam logic [6:0] SB = 7'b1111111;
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] ZL = SB;
`else
  localparam logic [6:0] ZL = S0;
`endif

  // clock / reset
  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] din;
  logic [3:0]  anode;
  logic [6:0]  ssd;
  logic        busy;
  logic [1:0]  state_dbg;

  always #5 clk = ~clk;

  ssd_scan_driver #(.REFRESH_W(RW), .SAT_VALUE(16'd9999)) dut (
    .clk          (clk),
    .reset        (reset),
    .displayNumber(din),
    .anode        (anode),
    .ssdOut       (ssd),
    .busy         (busy),
    .state_dbg_o  (state_dbg)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  int         m_cnt, m_last, m_disp, m_cap, m_rem;
  logic [3:0] m_anode;
  logic [6:0] m_seg;
  int         pow10 [4];
  logic [6:0] cap_seg [4];

  typedef struct packed {
    logic [15:0] value;
    logic [27:0] segs;   // {thousands, hundreds, tens, units}
  } vec_t;
  vec_t vecs [8];

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return S0;
      1: return S1;
      2: return S2;
      3: return S3;
      4: return S4;
      5: return S5;
      6: return S6;
      7: return S7;
      8: return S8;
      9: return S9;
      default: return SB;
    endcase
  endfunction

  function automatic logic [6:0] model_seg(input int value, input int pos);
`ifdef LEADING_ZERO_BLANK_EN
    if (pos > 0 && value < pow10[pos]) return SB;
`endif
    return seg_of((value / pow10[pos]) % 10);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    if (reset) begin
      m_cnt = 0; m_last = 0; m_disp = 0; m_rem = 0;
      m_anode = 4'b1110; m_seg = S0;
    end else begin
      m_anode = ~(4'b0001 << (m_cnt / (1 << (RW - 2))));
      m_seg   = model_seg(m_disp, m_cnt / (1 << (RW - 2)));
      m_cnt   = (m_cnt + 1) % (1 << RW);
      if (m_rem == 0) begin
        if (int'(din) != m_last) begin
          m_last = int'(din);
          m_cap  = (int'(din) > 9999) ? 9999 : int'(din);
          m_rem  = 17;
        end
      end else begin
        m_rem--;
        if (m_rem == 0) m_disp = m_cap;
      end
    end
  endtask

  // driver: one clock, model update, then compare away from the edge
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check("busy",   {31'd0, busy}, {31'd0, (m_rem != 0)});
    check("anode",  {28'd0, anode}, {28'd0, m_anode});
    check("ssdOut", {25'd0, ssd},   {25'd0, m_seg});
  endtask

  // drive a value, then measure the busy pulse length
  task automatic convert(input logic [15:0] v, input string name);
    int hi;
    din = v;
    cycle();
    hi = 0;
    for (int i = 0; i < 40 && busy; i++) begin
      hi++;
      cycle();
    end
    check(name, hi, 17);
  endtask

  task automatic capture_digits();
    cycle();
    for (int i = 0; i < 4; i++) cap_seg[i] = 7'bx;
    for (int i = 0; i < 16; i++) begin
      cycle();
      case (anode)
        4'b1110: cap_seg[0] = ssd;
        4'b1101: cap_seg[1] = ssd;
        4'b1011: cap_seg[2] = ssd;
        4'b0111: cap_seg[3] = ssd;
        default: ;
      endcase
    end
  endtask

  task automatic check_digits(input logic [27:0] segs, input string name);
    for (int i = 0; i < 4; i++) begin
      check(name, {25'd0, cap_seg[i]}, {25'd0, segs[i*7 +: 7]});
    end
  endtask

  initial begin
    logic [3:0] an_tab [4];
    int         hi;

    pow10[0] = 1; pow10[1] = 10; pow10[2] = 100; pow10[3] = 1000;
    an_tab[0] = 4'b1110; an_tab[1] = 4'b1101; an_tab[2] = 4'b1011; an_tab[3] = 4'b0111;

    vecs[0] = '{16'd1234,  {S1, S2, S3, S4}};
    vecs[1] = '{16'd50000, {S9, S9, S9, S9}};
    vecs[2] = '{16'd65535, {S9, S9, S9, S9}};
    vecs[3] = '{16'd42,    {ZL, ZL, S4, S2}};
    vecs[4] = '{16'd905,   {ZL, S9, S0, S5}};
    vecs[5] = '{16'd7,     {ZL, ZL, ZL, S7}};
    vecs[6] = '{16'd6180,  {S6, S1, S8, S0}};
    vecs[7] = '{16'd0,     {ZL, ZL, ZL, S0}};

    // reset state
    reset = 1'b1;
    din   = 16'd0;
    cycle();
    cycle();
    check("rst_busy",  {31'd0, busy}, 32'd0);
    check("rst_anode", {28'd0, anode}, {28'd0, 4'b1110});
    check("rst_ssd",   {25'd0, ssd},   {25'd0, S0});
    reset = 1'b0;

    // idle scan of zero: no conversion, anode rotates every 4 cycles
    for (int i = 0; i < 16; i++) begin
      cycle();
      check("idle_busy",  {31'd0, busy}, 32'd0);
      check("idle_anode", {28'd0, anode}, {28'd0, an_tab[i / 4]});
      check("idle_ssd",   {25'd0, ssd},   {25'd0, (i < 4) ? S0 : ZL});
    end

    // vector table
    for (int v = 0; v < 8; v++) begin
      convert(vecs[v].value, "busy_len");
      capture_digits();
      check_digits(vecs[v].segs, "digit");
    end

    // input change during conversion is deferred, not lost
    din = 16'd25;
    cycle();
    hi = busy ? 1 : 0;
    for (int i = 0; i < 40; i++) begin
      if (i == 2) din = 16'd150;
      cycle();
      if (busy) hi++;
    end
    check("deferred_busy_total", hi, 34);
    capture_digits();
    check_digits({ZL, S1, S5, S0}, "deferred_digit");

    // reset during SHIFT aborts and the unchanged input reconverts afterwards
    din = 16'd8888;
    cycle();
    for (int i = 0; i < 4; i++) cycle();
    reset = 1'b1;
    cycle();
    check("midrst_busy",  {31'd0, busy}, 32'd0);
    check("midrst_anode", {28'd0, anode}, {28'd0, 4'b1110});
    check("midrst_ssd",   {25'd0, ssd},   {25'd0, S0});
    reset = 1'b0;
    convert(16'd8888, "post_rst_busy_len");
    capture_digits();
    check_digits({S8, S8, S8, S8}, "post_rst_digit");

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        if ($urandom_range(0, 1) == 0) din = 16'($urandom_range(0, 99));
        else                           din = 16'($urandom_range(0, 65535));
      end
      reset = ($urandom_range(0, 149) == 0);
      cycle();
    end
    reset = 1'b0;
    for (int i = 0; i < 40; i++) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ssd_scan_driver.md
Name: ssd_scan_driver

Overview:
- Downstream consumer of the game core's sun count.
- Converts the 16-bit binary `displayNumber` to four BCD digits with a sequential double-dabble engine.
- Time-multiplexes the digits onto the four right-hand anodes of the Nexys4 7-segment display.
- The top level drives `An7..An4` high and maps `ssdOut` to `{Ca..Cg}`; the decimal point is not driven here.

Parameters:
- `REFRESH_W`, 20: refresh counter width. Digit select is `refresh_cnt[REFRESH_W-1:REFRESH_W-2]`, so each digit is shown for 2^(REFRESH_W-2) cycles (2.6 ms at 100 MHz).
- `SAT_VALUE`, 9999: any input above this displays as this value.

Ports:
- `clk` in 1: system clock (`ClkPort`, 100 MHz).
- `reset` in 1: synchronous, active-high reset.
- `displayNumber` in 16: unsigned binary value to show.
- `anode` out 4: digit enables, active-low; `anode[0]` = units (rightmost).
- `ssdOut` out 7: segments, active-low; `ssdOut[6]` = a … `ssdOut[0]` = g.
- `busy` out 1: high while a conversion is in flight.

Behaviour:
- Reset values:
  - `refresh_cnt` = 0, `last_value` = 0, `display_bcd` = 0x0000, state = IDLE.
  - `anode` = 4'b1110, `ssdOut` = 7'b0000001 (digit "0"), `busy` = 0.
- FSM states IDLE, SHIFT, DONE. `busy` = (state != IDLE), combinational from the state register.
- IDLE:
  - When `displayNumber` != `last_value` at edge k:
    - `last_value` <= `displayNumber`.
    - shift register <= min(`displayNumber`, `SAT_VALUE`) in bits [15:0], BCD field [15:0] cleared.
    - iteration counter <= 0; state <= SHIFT.
  - Otherwise stay in IDLE.
- SHIFT:
  - Each cycle, first add 3 to every BCD nibble >= 5, then shift {bcd, bin} left by 1.
  - 16 iterations, on edges k+1..k+16. On the edge performing iteration 15, state <= DONE.
- DONE: at edge k+17, `display_bcd` <= BCD result; state <= IDLE.
- Latency:
  - `display_bcd` updates 17 cycles after the sampling edge; `ssdOut` reflects it from edge k+18.
  - `busy` is high for exactly 17 cycles.
- Input changes during SHIFT/DONE are ignored. Back in IDLE, the new value is compared against `last_value`, so a change is never lost, only deferred. Back-to-back conversions are allowed with one IDLE cycle between them.
- Equal input after reset (0) triggers no conversion.
- The old `display_bcd` is held for the whole conversion, so no partial digits are ever shown.
- Saturation: 10000..65535 converts 9999 (same 17-cycle path); `last_value` still stores the raw input.
- Refresh:
  - `refresh_cnt` free-runs and wraps 2^REFRESH_W-1 -> 0.
  - Digit select `sel` = top 2 bits; 0 = units, 3 = thousands.
  - `anode` and `ssdOut` are registered from `sel`/`display_bcd` (1-cycle lag, both change on the same edge, no ghosting).
  - `anode` is one-hot-low: `sel` 0 -> 1110, 1 -> 1101, 2 -> 1011, 3 -> 0111.
- Segment codes (a..g, active-low):
  - 0 = 0000001, 1 = 1001111, 2 = 0010010, 3 = 0000110, 4 = 1001100
  - 5 = 0100100, 6 = 0100000, 7 = 0001111, 8 = 0000000, 9 = 0000100
  - blank = 1111111; nibble values 10..15 (unreachable) also map to blank.
- Reset mid-conversion aborts immediately: state IDLE and all registers return to their reset values. A nonzero input then reconverts on the first post-reset cycle.

Optional Feature:
- `LEADING_ZERO_BLANK_EN` defined:
  - A digit whose position is above the most significant nonzero digit outputs blank (1111111) while its anode still cycles normally.
  - Units is never blanked (value 0 shows "0").
  - 42 shows "  42".
- Undefined: all four digits are always shown (42 shows "0042").

Test Plan:
- Reset, then `REFRESH_W`=4, `displayNumber`=0 -> `busy` never rises; `anode` cycles 1110, 1101, 1011, 0111 every 4 cycles; `ssdOut`=0000001 on every digit.
- `displayNumber` 0 -> 1234 at edge k -> `busy` high edges k..k+16; `display_bcd`=0x1234 after edge k+17; scan shows 4, 3, 2, 1 as 1001100, 0000110, 0010010, 1001111.
- `displayNumber`=50000 -> `display_bcd`=0x9999, all digits 0000100; then 65535 -> no visible change, but one conversion runs (`busy` pulse of 17 cycles).
- Change 25 -> 150 mid-conversion (3 cycles after the 25 was sampled) -> 25 displayed at k+17; second conversion starts k+18; 0x0150 displayed at k+35.
- Assert `reset` during SHIFT of 8888 -> next cycle `busy`=0, `display_bcd`=0, `anode`=1110, `ssdOut`=0000001; release with input still 8888 -> 0x8888 displayed 17 cycles later.
- With `LEADING_ZERO_BLANK_EN`, `displayNumber`=7 -> digits 3..1 are 1111111, units is 0001111; without the macro, digits 3..1 are 0000001.
